inv_bist_16: RTL
================

Name: inv_bist_16

Overview:
- Built-in self-test engine for the 16-bit combinational inverter bank; it is the stimulus/check end of the inverter's interface.
- Drives a registered thermometer pattern onto `stim`, which feeds the DUT input bus.
- Samples the DUT output on `resp` after a programmable settle time and compares it against the bitwise complement of `stim`.
- Reports pass/fail, a mismatch count and the index of the first failing vector.

Parameters:
- WIDTH, 16, data bus width of stim/resp.
- SETTLE, 1, cycles `resp` settles after a `stim` update before sampling (legal range ≥1).
- NV, WIDTH+1 (2*WIDTH+1 with macro), number of vectors; derived, not overridable.
- CW, $clog2(NV+1), width of err_count and first_fail; derived.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch request
- stim  out  WIDTH  registered stimulus to DUT input
- resp  in  WIDTH  DUT output
- busy  out  1  run in progress
- done  out  1  run complete; held until next start
- pass  out  1  done and zero mismatches
- err_count  out  CW  mismatching vectors counted
- first_fail  out  CW  index of first mismatching vector; all-ones if none

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; stim=0; busy=0; done=0; pass=0; err_count=0; first_fail=all-ones; vector index k=0; settle counter=0.
- Vector k (0..WIDTH): stim = (1<<k)-1, i.e. low k bits set, cumulative.
  - k=0 → 0x0000, k=1 → 0x0001, …, k=16 → 0xFFFF.
- Expected response = ~stim. A vector mismatches if resp != ~stim in any bit.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 → SETTLE; k=0, stim=0, err_count=0, first_fail=all-ones, counter=SETTLE-1, busy=1, done=0, pass=0.
- SETTLE:
  - counter>0 → decrement and stay.
  - counter==0 → CHECK.
- CHECK (one cycle): compare resp to ~stim using the stim value already on the bus.
  - On mismatch: err_count+=1; if first_fail==all-ones, first_fail=k.
  - If k==NV-1 → DONE; busy=0; done=1; pass=(final err_count==0), including this cycle's result.
  - Else k+=1, stim=next vector, counter=SETTLE-1 → SETTLE.
- DONE:
  - Outputs hold, stim holds its last vector.
  - start=1 → same action as start in IDLE (restart).
- Timing: each vector takes SETTLE+1 cycles. With defaults, done rises on the 34th rising edge after the edge that samples start.
- start while busy is ignored; no effect on any counter.
- err_count saturates at NV by construction; no wrap.
- A reset mid-run aborts immediately to the reset values. No partial result is retained.
- pass is never 1 while busy=1.

Optional Feature:
- Macro: INV_BIST_WALK_ZERO_EN.
- Defined:
  - NV=2*WIDTH+1; a falling pass is appended after k=WIDTH.
  - For k=WIDTH+1..2*WIDTH: stim = ~((1<<(k-WIDTH))-1), i.e. the low (k-WIDTH) bits are cleared.
  - Sequence: 0xFFFE, 0xFFFC, …, 0x0000; the check rule is unchanged.
  - Default run is 66 cycles; CW recomputed accordingly.
- Undefined: rising pass only, NV=WIDTH+1, 34-cycle run.

Test Plan:
- Correct inverter (resp=~stim), pulse start → busy for 34 cycles, then done=1, pass=1, err_count=0, first_fail=all-ones; stim ends at 0xFFFF.
- resp bit5 stuck-at-0 → err_count=6 (k=0..5), first_fail=0, pass=0.
- resp bit15 stuck-at-1 → err_count=1, first_fail=16, pass=0; with INV_BIST_WALK_ZERO_EN: err_count=16 (k=16..31), first_fail=16, 66-cycle run.
- start re-pulsed at cycles 3 and 10 of a run → ignored; done still arrives at cycle 34 with unchanged results.
- rst_n low at cycle 12 → stim=0, busy=0, err_count=0, first_fail=all-ones immediately (async); later start gives a clean 34-cycle pass.
- SETTLE=3 with a DUT model delaying resp by 2 cycles → pass=1 and 68-cycle run; SETTLE=1 with the same DUT → pass=0.

Source files
------------

// File: rtl/inv_bist_16.sv
// inv_bist_16 -- built-in self-test engine for a 16-bit combinational inverter bank.
//
// Drives a registered thermometer pattern on stim, waits SETTLE cycles, then checks
// that resp is the bitwise complement of stim. Reports pass/fail, the number of
// mismatching vectors and the index of the first failing vector.
//
// Optional feature: define INV_BIST_WALK_ZERO_EN to append a falling pass
// (0xFFFE, 0xFFFC, ..., 0x0000) after the rising pass.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle launch request (ignored while busy)
//   stim       out  registered stimulus to the inverter input
//   resp       in   inverter output
//   busy       out  run in progress
//   done       out  run complete, held until the next start
//   pass       out  done with zero mismatches
//   err_count  out  number of mismatching vectors
//   first_fail out  index of the first mismatching vector, all-ones if none
module inv_bist_16 #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 1,
`ifdef INV_BIST_WALK_ZERO_EN
  localparam int unsigned NV    = 2 * WIDTH + 1,
`else
  localparam int unsigned NV    = WIDTH + 1,
`endif
  localparam int unsigned CW    = $clog2(NV + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] stim,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic [CW-1:0]    first_fail
);

  localparam int unsigned CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CNTW-1:0] CntInit = CNTW'(SETTLE - 1);
  localparam logic [CW-1:0]   LastK   = CW'(NV - 1);
  localparam logic [CW-1:0]   FfNone  = {CW{1'b1}};

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StCheck  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CW-1:0]    err_q, err_d;
  logic [CW-1:0]    ff_q, ff_d;

  logic mismatch;
  logic fill;

  assign mismatch = (resp != ~stim_q);

  // Next vector is a left shift; the shifted-in bit is 1 on the rising pass and
  // 0 once the falling pass begins (k >= WIDTH).
`ifdef INV_BIST_WALK_ZERO_EN
  assign fill = (k_q < CW'(WIDTH));
`else
  assign fill = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StSettle;
          k_d     = '0;
          cnt_d   = CntInit;
          stim_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ff_d    = FfNone;
        end
      end
      StSettle: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (mismatch) begin
          err_d = err_q + CW'(1);
          if (ff_q == FfNone) begin
            ff_d = k_q;
          end
        end
        if (k_q == LastK) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Final verdict must include this cycle's compare result.
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          state_d = StSettle;
          k_d     = k_q + CW'(1);
          cnt_d   = CntInit;
          stim_d  = {stim_q[WIDTH-2:0], fill};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= FfNone;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule
